// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// datapath_pkg : branch control / result encodings shared by the datapath
// Revision     : 1.0
// ============================================================================
package datapath_pkg;

   localparam int WIDTH = 16;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_LT   = 2'b01;
   localparam logic [1:0] BR_EQ   = 2'b10;
   localparam logic [1:0] BR_GT   = 2'b11;

   localparam logic [1:0] BRES_NONE      = 2'b00;
   localparam logic [1:0] BRES_TAKEN     = 2'b01;
   localparam logic [1:0] BRES_NOT_TAKEN = 2'b10;

endpackage
`default_nettype wire

// File: rtl/branch_comparator_if.sv
`default_nettype none
// ============================================================================
// branch_comparator_if : decode-side compare request and registered result
// Revision             : 1.0
// ============================================================================
interface branch_comparator_if
   import datapath_pkg::*;
#(
   parameter int WIDTH = datapath_pkg::WIDTH
);
   logic [1:0]       branch_control;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] r15;
   logic             flush;
   logic [1:0]       branch;

   modport master (
      output branch_control, op1, r15, flush,
      input  branch
   );

   modport slave (
      input  branch_control, op1, r15, flush,
      output branch
   );
endinterface
`default_nettype wire

// File: rtl/signed_cmp.sv
`default_nettype none
// ============================================================================
// signed_cmp : combinational two's-complement magnitude compare
// Revision   : 1.0
// ============================================================================
module signed_cmp #(
   parameter int WIDTH = 16
) (
   input  wire logic [WIDTH-1:0] a,
   input  wire logic [WIDTH-1:0] b,
   output logic                  lt,
   output logic                  eq,
   output logic                  gt
);
   assign lt = $signed(a) < $signed(b);
   assign eq = (a == b);
   assign gt = ~lt & ~eq;
endmodule
`default_nettype wire

// File: rtl/branch_comparator.sv
`default_nettype none
// ============================================================================
// branch_comparator : resolves op1-vs-R15 branch condition, one-cycle result
// Revision          : 1.0
// ============================================================================
module branch_comparator
   import datapath_pkg::*;
#(
   parameter int WIDTH = datapath_pkg::WIDTH
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   branch_comparator_if.slave bus
);
   logic       lt;
   logic       eq;
   logic       gt;
   logic [1:0] branch_d;
   logic [1:0] branch_q;

   signed_cmp #(.WIDTH(WIDTH)) u_cmp (
      .a  (bus.op1),
      .b  (bus.r15),
      .lt (lt),
      .eq (eq),
      .gt (gt)
   );

   // Unknown control falls to the default arm so X never yields "taken".
   always_comb begin
      branch_d = BRES_NONE;
      if (!bus.flush) begin
         case (bus.branch_control)
            BR_LT:   branch_d = lt ? BRES_TAKEN : BRES_NOT_TAKEN;
            BR_EQ:   branch_d = eq ? BRES_TAKEN : BRES_NOT_TAKEN;
            BR_GT:   branch_d = gt ? BRES_TAKEN : BRES_NOT_TAKEN;
            default: branch_d = BRES_NONE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_q <= BRES_NONE;
      end else begin
         branch_q <= branch_d;
      end
   end

   assign bus.branch = branch_q;
endmodule
`default_nettype wire

// File: tb/tb_branch_comparator.sv
`default_nettype none
// ============================================================================
// tb_branch_comparator : directed self-checking bench for branch_comparator
// Revision             : 1.0
// ============================================================================
module tb_branch_comparator;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   branch_comparator_if #(.WIDTH(16)) bus ();

   branch_comparator #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] bc, input logic [15:0] a,
                        input logic [15:0] b, input logic fl);
      bus.branch_control = bc;
      bus.op1            = a;
      bus.r15            = b;
      bus.flush          = fl;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(2'b01, 16'd5, 16'd10, 1'b0);
      #1;
      checks++;
      if (bus.branch !== 2'b00) begin
         errors++;
         $display("FAIL reset_initial got %b expected 00", bus.branch);
      end
      repeat (2) step();
      checks++;
      if (bus.branch !== 2'b00) begin
         errors++;
         $display("FAIL reset_held got %b expected 00", bus.branch);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (bus.branch !== 2'b01) begin
         errors++;
         $display("FAIL reset_release got %b expected 01", bus.branch);
      end
      // asynchronous assertion mid-cycle, away from any edge
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.branch !== 2'b00) begin
         errors++;
         $display("FAIL reset_async got %b expected 00", bus.branch);
      end
      step();
      checks++;
      if (bus.branch !== 2'b00) begin
         errors++;
         $display("FAIL reset_async_held got %b expected 00", bus.branch);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (bus.branch !== 2'b01) begin
         errors++;
         $display("FAIL reset_rerelease got %b expected 01", bus.branch);
      end
   endtask

   task automatic test_no_branch();
      drive(2'b00, 16'd10, 16'd5, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b00) begin
         errors++;
         $display("FAIL none_gt got %b expected 00", bus.branch);
      end
      drive(2'b00, 16'd5, 16'd10, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b00) begin
         errors++;
         $display("FAIL none_lt got %b expected 00", bus.branch);
      end
   endtask

   task automatic test_blt();
      drive(2'b01, 16'd5, 16'd10, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b01) begin
         errors++;
         $display("FAIL blt_taken got %b expected 01", bus.branch);
      end
      drive(2'b01, 16'd10, 16'd5, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b10) begin
         errors++;
         $display("FAIL blt_not_taken got %b expected 10", bus.branch);
      end
   endtask

   task automatic test_beq();
      drive(2'b10, 16'd10, 16'd5, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b10) begin
         errors++;
         $display("FAIL beq_not_taken got %b expected 10", bus.branch);
      end
      drive(2'b10, 16'd5, 16'd5, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b01) begin
         errors++;
         $display("FAIL beq_taken got %b expected 01", bus.branch);
      end
   endtask

   task automatic test_bgt_boundary();
      drive(2'b11, 16'h7FFF, 16'h8000, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b01) begin
         errors++;
         $display("FAIL bgt_max_vs_min got %b expected 01", bus.branch);
      end
      drive(2'b01, 16'h7FFF, 16'h8000, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b10) begin
         errors++;
         $display("FAIL blt_max_vs_min got %b expected 10", bus.branch);
      end
      drive(2'b01, 16'h8000, 16'h7FFF, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b01) begin
         errors++;
         $display("FAIL blt_min_vs_max got %b expected 01", bus.branch);
      end
      drive(2'b01, 16'h8000, 16'h8000, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b10) begin
         errors++;
         $display("FAIL blt_equal got %b expected 10", bus.branch);
      end
      drive(2'b11, 16'h8000, 16'h8000, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b10) begin
         errors++;
         $display("FAIL bgt_equal got %b expected 10", bus.branch);
      end
   endtask

   task automatic test_flush();
      drive(2'b10, 16'd7, 16'd7, 1'b1);
      step();
      checks++;
      if (bus.branch !== 2'b00) begin
         errors++;
         $display("FAIL flush_beq got %b expected 00", bus.branch);
      end
      drive(2'b10, 16'd7, 16'd7, 1'b0);
      step();
      checks++;
      if (bus.branch !== 2'b01) begin
         errors++;
         $display("FAIL flush_release got %b expected 01", bus.branch);
      end
      drive(2'b11, 16'd9, 16'd1, 1'b1);
      step();
      checks++;
      if (bus.branch !== 2'b00) begin
         errors++;
         $display("FAIL flush_bgt got %b expected 00", bus.branch);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a_v [6];
      logic [15:0] b_v [6];
      logic [1:0]  c_v [6];
      logic [1:0]  e_v [6];
      logic [1:0]  prev;
      a_v = '{16'd1, 16'd2, 16'hFFFF, 16'd0,    16'd3, 16'hFFFE};
      b_v = '{16'd2, 16'd1, 16'd0,    16'hFFFF, 16'd3, 16'hFFFF};
      c_v = '{2'b01, 2'b01, 2'b01,    2'b11,    2'b10, 2'b11};
      e_v = '{2'b01, 2'b10, 2'b01,    2'b01,    2'b01, 2'b10};
      prev = 2'b00;
      for (int i = 0; i < 6; i++) begin
         drive(c_v[i], a_v[i], b_v[i], 1'b0);
         #3;
         checks++;
         if (bus.branch !== prev) begin
            errors++;
            $display("FAIL b2b_hold[%0d] got %b expected %b", i, bus.branch, prev);
         end
         step();
         checks++;
         if (bus.branch !== e_v[i]) begin
            errors++;
            $display("FAIL b2b_result[%0d] got %b expected %b", i, bus.branch, e_v[i]);
         end
         prev = e_v[i];
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_no_branch();
      test_blt();
      test_beq();
      test_bgt_boundary();
      test_flush();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
